bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 48 ++++
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the master-side request/strobe/data buses and the single slave-side
// bus that the arbiter multiplexes onto.
//
// Modports:
//   master : arbiter view. It samples the master requests and strobes and
//            drives the grants, the slave-side bus and the read-data broadcast.
//   slave  : environment view (masters plus slave), the mirror of master.
//
// Signals:
//   mst_req   [NUM_MST]    per-master request
//   mst_grant [NUM_MST]    one-hot-or-zero grant
//   mst_addr  [8*NUM_MST]  master i address in bits [8i+7:8i]
//   mst_wr    [NUM_MST]    per-master write strobe
//   mst_rd    [NUM_MST]    per-master read strobe
//   mst_wdata [8*NUM_MST]  master i write data in bits [8i+7:8i]
//   mst_rdata [8]          slave read data broadcast to all masters
//   slv_addr/slv_wr/slv_rd/slv_wdata  granted master's bus toward the slave
//   slv_rdata [8]          read data returned by the slave
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NUM_MST = 3
);
    logic [NUM_MST-1:0]   mst_req;
    logic [NUM_MST-1:0]   mst_grant;
    logic [8*NUM_MST-1:0] mst_addr;
    logic [NUM_MST-1:0]   mst_wr;
    logic [NUM_MST-1:0]   mst_rd;
    logic [8*NUM_MST-1:0] mst_wdata;
    logic [7:0]           mst_rdata;

    logic [7:0]           slv_addr;
    logic                 slv_wr;
    logic                 slv_rd;
    logic [7:0]           slv_wdata;
    logic [7:0]           slv_rdata;

    modport master (
        input  mst_req, mst_addr, mst_wr, mst_rd, mst_wdata, slv_rdata,
        output mst_grant, mst_rdata, slv_addr, slv_wr, slv_rd, slv_wdata
    );

    modport slave (
        output mst_req, mst_addr, mst_wr, mst_rd, mst_wdata, slv_rdata,
        input  mst_grant, mst_rdata, slv_addr, slv_wr, slv_rd, slv_wdata
    );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Three-master (CPU=0, DMA=1, debug=2) to one-slave bus arbiter. Ownership is
// held for as long as the owner keeps its request up; on release the bus is
// handed straight to the next pending requester without an idle cycle.
//
// Arbitration:
//   default build             : fixed priority 2 > 0 > 1
//   BUS_ARB_ROUND_ROBIN_EN     : first requester after the last owner in the
//                                cyclic order 0->1->2->0; the last-owner
//                                pointer restarts at master 0 after reset
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   bus            bus_arbiter_if.master (requests, strobes, grants, slave bus)
//   contention_cnt saturating count of cycles a request waited on another owner
//   bus_busy       high whenever any grant is set
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_MST = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_if.master    bus,
    output logic [CNT_W-1:0] contention_cnt,
    output logic             bus_busy
);

    // state | meaning
    // IDLE  | no master owns the bus, all slave outputs forced to 0
    // OWN0  | CPU owns the bus
    // OWN1  | DMA owns the bus
    // OWN2  | debug owns the bus
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        OWN2 = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    state_t             winner;
    logic [NUM_MST-1:0] grant;
    logic               contend;

    function automatic state_t owner_state(input logic [1:0] idx);
        case (idx)
            2'd0:    return OWN0;
            2'd1:    return OWN1;
            default: return OWN2;
        endcase
    endfunction

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0] last_owner;

    // Walk the cyclic order starting just after the last owner; the first
    // requester met wins.
    function automatic state_t pick_rr(input logic [NUM_MST-1:0] r,
                                       input logic [1:0]         last);
        state_t     w;
        logic [1:0] idx;
        w   = IDLE;
        idx = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (w == IDLE && r[idx]) begin
                w = owner_state(idx);
            end
        end
        return w;
    endfunction

    always_comb begin
        winner = pick_rr(bus.mst_req, last_owner);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= 2'd0;
        end else begin
            case (next_state)
                OWN0:    last_owner <= 2'd0;
                OWN1:    last_owner <= 2'd1;
                OWN2:    last_owner <= 2'd2;
                default: last_owner <= last_owner;
            endcase
        end
    end
`else
    function automatic state_t pick_fixed(input logic [NUM_MST-1:0] r);
        if (r[2]) begin
            return OWN2;
        end else if (r[0]) begin
            return OWN0;
        end else if (r[1]) begin
            return OWN1;
        end
        return IDLE;
    endfunction

    always_comb begin
        winner = pick_fixed(bus.mst_req);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // On release the owner's own request bit is already 0, so the shared
    // winner naturally only considers the other masters, including any that
    // raised their request in this very cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = winner;
            OWN0:    if (!bus.mst_req[0]) next_state = winner;
            OWN1:    if (!bus.mst_req[1]) next_state = winner;
            OWN2:    if (!bus.mst_req[2]) next_state = winner;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        case (state)
            OWN0:    grant[0] = 1'b1;
            OWN1:    grant[1] = 1'b1;
            OWN2:    grant[2] = 1'b1;
            default: grant    = '0;
        endcase
    end

    assign bus.mst_grant = grant;
    assign bus_busy      = |grant;
    assign bus.mst_rdata = bus.slv_rdata;

    // Only the granted master's lanes are selected, so strobes from waiting
    // masters can never leak onto the slave side.
    always_comb begin
        bus.slv_addr  = 8'h00;
        bus.slv_wr    = 1'b0;
        bus.slv_rd    = 1'b0;
        bus.slv_wdata = 8'h00;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant[i]) begin
                bus.slv_addr  = bus.mst_addr[8*i +: 8];
                bus.slv_wr    = bus.mst_wr[i];
                bus.slv_rd    = bus.mst_rd[i];
                bus.slv_wdata = bus.mst_wdata[8*i +: 8];
            end
        end
    end

    assign contend = (|grant) && (|(bus.mst_req & ~grant));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            contention_cnt <= '0;
        end else if (contend && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] contention_cnt;
    logic       bus_busy;

    bus_arbiter_if #(.NUM_MST(3)) bus ();

    bus_arbiter #(.NUM_MST(3), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .contention_cnt (contention_cnt),
        .bus_busy       (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] e_grant;
        logic       e_wr;
        logic       e_rd;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic [7:0] e_rdata;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t sb[$];
    vec_t mon_v;
    int   checks = 0;
    int   errors = 0;
    int   nvec   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", nm, nvec, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what the
    // outputs must show during that cycle.
    task automatic step(input logic r, input logic [2:0] q, input logic [2:0] w,
                        input logic [2:0] d, input logic [2:0] eg, input logic [7:0] ec);
        vec_t v;
        logic [7:0] rdv;
        @(posedge clk);
        #1;
        rdv = 8'h5A ^ 8'(nvec);
        rst           = r;
        bus.mst_req   = q;
        bus.mst_wr    = w;
        bus.mst_rd    = d;
        bus.slv_rdata = rdv;
        v.e_grant = eg;
        v.e_wr    = |(eg & w);
        v.e_rd    = |(eg & d);
        v.e_addr  = eg[0] ? 8'h3C : eg[1] ? 8'hB1 : eg[2] ? 8'hA2 : 8'h00;
        v.e_wdata = eg[0] ? 8'h50 : eg[1] ? 8'h51 : eg[2] ? 8'h52 : 8'h00;
        v.e_rdata = rdv;
        v.e_cnt   = ec;
        sb.push_back(v);
        nvec++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_v = sb.pop_front();
            chk("grant",     {5'd0, bus.mst_grant}, {5'd0, mon_v.e_grant});
            chk("slv_addr",  bus.slv_addr,          mon_v.e_addr);
            chk("slv_wr",    {7'd0, bus.slv_wr},    {7'd0, mon_v.e_wr});
            chk("slv_rd",    {7'd0, bus.slv_rd},    {7'd0, mon_v.e_rd});
            chk("slv_wdata", bus.slv_wdata,         mon_v.e_wdata);
            chk("mst_rdata", bus.mst_rdata,         mon_v.e_rdata);
            chk("bus_busy",  {7'd0, bus_busy},      {7'd0, |mon_v.e_grant});
            chk("cnt",       contention_cnt,        mon_v.e_cnt);
        end
    end

    initial begin
        rst           = 1'b1;
        bus.mst_req   = 3'b000;
        bus.mst_wr    = 3'b000;
        bus.mst_rd    = 3'b000;
        bus.mst_addr  = {8'hA2, 8'hB1, 8'h3C};
        bus.mst_wdata = {8'h52, 8'h51, 8'h50};
        bus.slv_rdata = 8'h00;
        #2 rst = 1'b0;

        // reset holds everything at zero even with requests and strobes up
        step(0, 3'b111, 3'b111, 3'b111, 3'b000, 8'd0);
        step(0, 3'b111, 3'b111, 3'b111, 3'b000, 8'd0);
        // single request, one-cycle grant latency
        step(1, 3'b001, 3'b000, 3'b000, 3'b000, 8'd0);
        // master 0 holds while master 1 waits and writes
        step(1, 3'b011, 3'b010, 3'b001, 3'b001, 8'd0);
        step(1, 3'b011, 3'b010, 3'b000, 3'b001, 8'd1);
        step(1, 3'b011, 3'b010, 3'b000, 3'b001, 8'd2);
        step(1, 3'b011, 3'b010, 3'b000, 3'b001, 8'd3);
        step(1, 3'b011, 3'b010, 3'b000, 3'b001, 8'd4);
        step(1, 3'b011, 3'b011, 3'b000, 3'b001, 8'd5);
        // master 0 releases, direct handover to master 1
        step(1, 3'b010, 3'b010, 3'b000, 3'b001, 8'd6);
        step(1, 3'b010, 3'b010, 3'b000, 3'b010, 8'd7);
        step(1, 3'b000, 3'b000, 3'b000, 3'b010, 8'd7);
        // all three request from idle: 100, 001, 010 with no gap
        step(1, 3'b111, 3'b000, 3'b000, 3'b000, 8'd7);
        step(1, 3'b111, 3'b000, 3'b000, 3'b100, 8'd7);
        step(1, 3'b011, 3'b000, 3'b000, 3'b100, 8'd8);
        step(1, 3'b011, 3'b000, 3'b000, 3'b001, 8'd9);
        step(1, 3'b010, 3'b000, 3'b000, 3'b001, 8'd10);
        step(1, 3'b010, 3'b000, 3'b000, 3'b010, 8'd11);
        step(1, 3'b000, 3'b000, 3'b000, 3'b010, 8'd11);
        // a request withdrawn while waiting is never granted
        step(1, 3'b100, 3'b000, 3'b000, 3'b000, 8'd11);
        step(1, 3'b101, 3'b000, 3'b000, 3'b100, 8'd11);
        step(1, 3'b100, 3'b000, 3'b000, 3'b100, 8'd12);
        step(1, 3'b000, 3'b000, 3'b000, 3'b100, 8'd12);
        step(1, 3'b000, 3'b000, 3'b000, 3'b000, 8'd12);
        // request rising in the release cycle takes over directly
        step(1, 3'b001, 3'b000, 3'b000, 3'b000, 8'd12);
        step(1, 3'b001, 3'b000, 3'b000, 3'b001, 8'd12);
        step(1, 3'b010, 3'b000, 3'b000, 3'b001, 8'd12);
        step(1, 3'b010, 3'b000, 3'b000, 3'b010, 8'd13);
        step(1, 3'b000, 3'b000, 3'b000, 3'b010, 8'd13);
        // owner and waiter drop together -> idle
        step(1, 3'b011, 3'b000, 3'b000, 3'b000, 8'd13);
        step(1, 3'b011, 3'b000, 3'b000, 3'b001, 8'd13);
        step(1, 3'b000, 3'b000, 3'b000, 3'b001, 8'd14);
        step(1, 3'b000, 3'b000, 3'b000, 3'b000, 8'd14);
        // long contention: counter saturates at FF
        step(1, 3'b011, 3'b000, 3'b000, 3'b000, 8'd14);
        for (int k = 0; k < 300; k++) begin
            step(1, 3'b011, 3'b000, 3'b000, 3'b001, (14 + k > 255) ? 8'hFF : 8'(14 + k));
        end
        step(1, 3'b011, 3'b000, 3'b000, 3'b001, 8'hFF);
        step(1, 3'b010, 3'b000, 3'b000, 3'b001, 8'hFF);
        step(1, 3'b010, 3'b010, 3'b000, 3'b010, 8'hFF);
        // reset during OWN1 with a write in flight: cleared before any edge
        step(0, 3'b010, 3'b010, 3'b000, 3'b000, 8'd0);
        step(0, 3'b010, 3'b010, 3'b000, 3'b000, 8'd0);
        step(1, 3'b111, 3'b000, 3'b000, 3'b000, 8'd0);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        // pointer restarts at master 0: 010, 100, 001
        step(1, 3'b111, 3'b000, 3'b000, 3'b010, 8'd0);
        step(1, 3'b101, 3'b000, 3'b000, 3'b010, 8'd1);
        step(1, 3'b001, 3'b000, 3'b000, 3'b100, 8'd2);
        step(1, 3'b000, 3'b000, 3'b000, 3'b001, 8'd3);
        step(1, 3'b000, 3'b000, 3'b000, 3'b000, 8'd3);
`else
        step(1, 3'b111, 3'b000, 3'b000, 3'b100, 8'd0);
        step(1, 3'b011, 3'b000, 3'b000, 3'b100, 8'd1);
        step(1, 3'b010, 3'b000, 3'b000, 3'b001, 8'd2);
        step(1, 3'b000, 3'b000, 3'b000, 3'b010, 8'd3);
        step(1, 3'b000, 3'b000, 3'b000, 3'b000, 8'd3);
`endif
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
